// File: rtl/interrupt_ctrl.sv
// ============================================================================
//  Module      : interrupt_ctrl
//  Description : Single-level interrupt controller; redirects fetch to a fixed
//                ISR vector on a latched IRQ edge and back on RTI.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module interrupt_ctrl #(
    parameter int              PC_W       = 12,
    parameter logic [PC_W-1:0] ISR_VECTOR = 12'h010
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            IEN_d,
    input  logic            IOF_d,
    input  logic            RTI_d,
    input  logic            branch_d,
    input  logic            IRQ,
    input  logic [PC_W-1:0] PC,
    output logic            branch_ISR,
    output logic [PC_W-1:0] ISR_adr
);

    logic            r_ien;
    logic            r_pending;
    logic            r_in_isr;
    logic            r_irq_q;
    logic [PC_W-1:0] r_saved_pc;
    logic            r_branch_isr;
    logic [PC_W-1:0] r_isr_adr;

    logic w_irq_rise;
    logic w_entry;
    logic w_return;

    assign w_irq_rise = IRQ & ~r_irq_q;

    // Entry and return are mutually exclusive through in_isr; both are blocked
    // while a redirect pulse is in flight, which keeps pulses one cycle wide.
    assign w_entry  = r_pending & r_ien & ~r_in_isr & ~branch_d & ~RTI_d & ~r_branch_isr;
    assign w_return = RTI_d & r_in_isr & ~r_branch_isr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ien        <= 1'b0;
            r_pending    <= 1'b0;
            r_in_isr     <= 1'b0;
            r_irq_q      <= 1'b0;
            r_saved_pc   <= '0;
            r_branch_isr <= 1'b0;
            r_isr_adr    <= '0;
        end else begin
            r_irq_q <= IRQ;

            if (w_entry)
                r_ien <= 1'b0;
            else if (w_return)
                r_ien <= 1'b1;
            else if (IOF_d)
                r_ien <= 1'b0;
            else if (IEN_d)
                r_ien <= 1'b1;

            // A fresh rise coinciding with entry must survive as a new request.
            if (w_irq_rise)
                r_pending <= 1'b1;
            else if (w_entry)
                r_pending <= 1'b0;

            r_branch_isr <= w_entry | w_return;

            if (w_entry) begin
                r_isr_adr  <= ISR_VECTOR;
                r_saved_pc <= PC;
                r_in_isr   <= 1'b1;
            end else if (w_return) begin
                r_isr_adr  <= r_saved_pc;
                r_in_isr   <= 1'b0;
            end
        end
    end

    assign branch_ISR = r_branch_isr;
    assign ISR_adr    = r_isr_adr;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_ctrl.sv
// ============================================================================
//  Module      : tb_interrupt_ctrl
//  Description : Directed self-checking bench for interrupt_ctrl.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_ctrl;

    logic        clock;
    logic        reset_n;
    logic        IEN_d;
    logic        IOF_d;
    logic        RTI_d;
    logic        branch_d;
    logic        IRQ;
    logic [11:0] PC;
    logic        branch_ISR;
    logic [11:0] ISR_adr;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .IEN_d      (IEN_d),
        .IOF_d      (IOF_d),
        .RTI_d      (RTI_d),
        .branch_d   (branch_d),
        .IRQ        (IRQ),
        .PC         (PC),
        .branch_ISR (branch_ISR),
        .ISR_adr    (ISR_adr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        IEN_d    = 1'b0;
        IOF_d    = 1'b0;
        RTI_d    = 1'b0;
        branch_d = 1'b0;
        IRQ      = 1'b0;
        PC       = 12'd35;
        #3;
        chk("reset_branch", {31'd0, branch_ISR}, 32'd0);
        chk("reset_adr", {20'd0, ISR_adr}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("reset_ien", {31'd0, dut.r_ien}, 32'd0);

        // Reset then enable; IRQ held high yields exactly one entry
        IEN_d = 1'b1;
        step();
        IEN_d = 1'b0;
        chk("en_ien", {31'd0, dut.r_ien}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        IRQ = 1'b1;
        step();
        chk("en_latch_nopulse", {31'd0, branch_ISR}, 32'd0);
        step();
        chk("en_pulse", {31'd0, branch_ISR}, 32'd1);
        chk("en_adr", {20'd0, ISR_adr}, 32'h010);
        chk("en_saved_pc", {20'd0, dut.r_saved_pc}, 32'd35);
        chk("en_ien_clr", {31'd0, dut.r_ien}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_single_pulse", {31'd0, branch_ISR}, 32'd0);
        end
        chk("en_in_isr", {31'd0, dut.r_in_isr}, 32'd1);

        // Return to saved PC; second RTI ignored
        PC    = 12'd200;
        RTI_d = 1'b1;
        step();
        RTI_d = 1'b0;
        chk("rti_pulse", {31'd0, branch_ISR}, 32'd1);
        chk("rti_adr", {20'd0, ISR_adr}, 32'd35);
        chk("rti_ien", {31'd0, dut.r_ien}, 32'd1);
        chk("rti_in_isr", {31'd0, dut.r_in_isr}, 32'd0);
        step();
        chk("rti_pulse_end", {31'd0, branch_ISR}, 32'd0);
        RTI_d = 1'b1;
        step();
        RTI_d = 1'b0;
        chk("rti2_nopulse", {31'd0, branch_ISR}, 32'd0);
        chk("rti2_adr_hold", {20'd0, ISR_adr}, 32'd35);
        IRQ = 1'b0;
        step();

        // Masked request, later enabled
        IOF_d = 1'b1;
        step();
        IOF_d = 1'b0;
        chk("mask_ien", {31'd0, dut.r_ien}, 32'd0);
        IRQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mask_nopulse", {31'd0, branch_ISR}, 32'd0);
        end
        IEN_d = 1'b1;
        step();
        IEN_d = 1'b0;
        chk("mask_en_nopulse", {31'd0, branch_ISR}, 32'd0);
        step();
        chk("mask_pulse", {31'd0, branch_ISR}, 32'd1);
        chk("mask_adr", {20'd0, ISR_adr}, 32'h010);
        step();
        RTI_d = 1'b1;
        step();
        RTI_d = 1'b0;
        chk("mask_rti_adr", {20'd0, ISR_adr}, 32'd200);
        step();
        IRQ = 1'b0;
        step();

        // Branch deferral
        PC       = 12'd300;
        branch_d = 1'b1;
        IRQ      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("defer_nopulse", {31'd0, branch_ISR}, 32'd0);
        end
        branch_d = 1'b0;
        PC       = 12'd301;
        step();
        chk("defer_pulse", {31'd0, branch_ISR}, 32'd1);
        chk("defer_adr", {20'd0, ISR_adr}, 32'h010);
        step();
        RTI_d = 1'b1;
        step();
        RTI_d = 1'b0;
        chk("defer_rti_adr", {20'd0, ISR_adr}, 32'd301);
        step();
        IRQ = 1'b0;
        step();

        // Priority and nesting
        IEN_d = 1'b1;
        IOF_d = 1'b1;
        step();
        IOF_d = 1'b0;
        chk("prio_iof_wins", {31'd0, dut.r_ien}, 32'd0);
        step();
        IEN_d = 1'b0;
        PC    = 12'd400;
        IRQ   = 1'b1;
        step();
        step();
        chk("nest_entry", {31'd0, branch_ISR}, 32'd1);
        step();
        IRQ = 1'b0;
        step();
        IRQ   = 1'b1;
        IEN_d = 1'b1;
        step();
        IEN_d = 1'b0;
        chk("nest_ien_in_isr", {31'd0, dut.r_ien}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("nest_blocked", {31'd0, branch_ISR}, 32'd0);
        end
        PC    = 12'd500;
        RTI_d = 1'b1;
        step();
        RTI_d = 1'b0;
        chk("nest_rti_pulse", {31'd0, branch_ISR}, 32'd1);
        chk("nest_rti_adr", {20'd0, ISR_adr}, 32'd400);
        step();
        chk("nest_gap", {31'd0, branch_ISR}, 32'd0);
        step();
        chk("nest_reentry", {31'd0, branch_ISR}, 32'd1);
        chk("nest_reentry_adr", {20'd0, ISR_adr}, 32'h010);
        step();

        // Asynchronous reset while in the ISR
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("areset_branch", {31'd0, branch_ISR}, 32'd0);
        chk("areset_adr", {20'd0, ISR_adr}, 32'd0);
        chk("areset_in_isr", {31'd0, dut.r_in_isr}, 32'd0);
        step();
        reset_n = 1'b1;
        IRQ     = 1'b0;
        RTI_d   = 1'b1;
        step();
        chk("areset_rti_nopulse", {31'd0, branch_ISR}, 32'd0);
        RTI_d = 1'b0;
        step();
        chk("areset_rti_nopulse2", {31'd0, branch_ISR}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
